// File: rtl/next_mem_arbiter.sv
// Round-robin arbiter sharing one NextMemory port between instruction fetch (I)
// and load/store (D). Writes complete in the grant cycle; at most one read is in
// flight, and its data is passed straight through to the owner after RD_LAT cycles.
module next_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  localparam logic       OwnI    = 1'b0;
  localparam logic       OwnD    = 1'b1;
  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic       last_gnt_q, last_gnt_d;
  logic       grant_i, grant_d;

  // Arbitration, memory strobes and read-data return. Everything is held at zero
  // while rst_n is low so the outputs are quiet during reset.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    last_gnt_d = last_gnt_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
    mem_waddr  = '0;
    mem_raddr  = '0;
    mem_wdata  = '0;

    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          // On a conflict the requester that did not win last time goes first.
          if (i_req && d_req) begin
            grant_d = (last_gnt_q == OwnI);
            grant_i = ~grant_d;
          end else begin
            grant_i = i_req;
            grant_d = d_req;
          end

          if (grant_d) begin
            d_gnt      = 1'b1;
            last_gnt_d = OwnD;
            if (d_we) begin
              mem_wen   = 1'b1;
              mem_waddr = d_addr;
              mem_wdata = d_wdata;
            end else begin
              mem_ren   = 1'b1;
              mem_raddr = d_addr;
              state_d   = StRdWait;
              owner_d   = OwnD;
              lat_cnt_d = LatInit;
            end
          end

          if (grant_i) begin
            i_gnt      = 1'b1;
            last_gnt_d = OwnI;
            mem_ren    = 1'b1;
            mem_raddr  = i_addr;
            state_d    = StRdWait;
            owner_d    = OwnI;
            lat_cnt_d  = LatInit;
          end
        end

        StRdWait: begin
          if (lat_cnt_q == 2'd0) begin
            state_d = StIdle;
            if (owner_q == OwnD) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else begin
              i_rvalid = 1'b1;
              i_rdata  = mem_rdata;
            end
          end else begin
            lat_cnt_d = lat_cnt_q - 2'd1;
          end
        end
      endcase
    end
  end

  // State registers; synchronous reset drops any pending read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= OwnI;
      lat_cnt_q  <= 2'd0;
      last_gnt_q <= OwnI;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule
